fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Two-stage instruction fetch front end.
- Stage 1 is a direct-indexed instruction cache with a synchronous write port; it registers one 32-byte block and the PC byte offset per cycle.
- Stage 2 is combinational. It extracts up to two variable-length instructions (A, B) from the registered block and reports how many bytes were consumed, so the PC controller can advance.

Parameters:
- BLOCK_SIZE, 32, bytes per cache line.
- BITS_PER_BYTE, 8, bits per byte.
- CACHE_LINES, 256, number of lines; index width is log2(CACHE_LINES) = 8.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- pc_i  in  16  fetch byte address; [4:0] byte offset, [12:5] line index, [15:13] ignored (aliases).
- writeEnable_i  in  1  cache line write strobe.
- writeAddress_i  in  16  write byte address; line index = [12:5], [4:0] ignored.
- writeBlock_i  in  256  line data; byte k = bits [8k+7:8k].
- InstructionA_o  in/out: out  64  first instruction, little-endian, zero-extended.
- InstructionB_o  out  64  second instruction, same packing.
- InstructionAFormat_o  out  1  0 = short (4 bytes), 1 = long (8 bytes).
- InstructionBFormat_o  out  1  as above, for B.
- enableA_o  out  1  InstructionA_o valid.
- enableB_o  out  1  InstructionB_o valid.
- nextByteOffset_o  out  4  bytes consumed this cycle.
- backDisable_o  out  1  instruction A crosses the block end; nothing issued.

Behaviour:
- Storage: CACHE_LINES x 256-bit array.
  - Written on a rising edge when writeEnable_i = 1.
  - Contents are not cleared by reset.
- Stage 1 registers, updated each rising edge:
  - blk_q <= line[pc_i[12:5]]
  - off_q <= pc_i[4:0]
  - vld_q <= 1
- Read during write to the same line returns the old data (read-before-write). Write data is visible from the next edge.
- Reset (reset_i = 0, asynchronous):
  - vld_q = 0, blk_q = 0, off_q = 0.
  - Hence all outputs are 0 while reset is asserted and until the first edge after release.
- Latency: one cycle. Outputs reflect the pc_i sampled at the most recent edge.
- Stage 2 (combinational from the stage 1 registers):
  - Format of the instruction starting at byte p = bit 7 of byte p.
  - Length: 4 bytes if format = 0, 8 bytes if format = 1.
  - A starts at off_q.
    - If vld_q = 0: all outputs 0.
    - If off_q + lenA > 32: enableA_o = 0, enableB_o = 0, backDisable_o = 1, nextByteOffset_o = 32 − off_q (range 1..7).
    - Otherwise: enableA_o = 1, InstructionA_o = bytes [off_q .. off_q+lenA−1], byte off_q in bits [7:0].
  - B starts at off_q + lenA. It is issued (enableB_o = 1) only if A is issued, B fits in the block, and not both A and B are long.
    - Consequence: max consumption is 12 bytes, which fits 4 bits.
  - nextByteOffset_o = lenA + (enableB_o ? lenB : 0) when A is issued.
- Invalid outputs:
  - When an enable is 0, the matching instruction and format outputs are 0.
  - backDisable_o = 0 whenever A is issued.
- Short instructions occupy bits [31:0]; bits [63:32] = 0.
- All outputs are stable from shortly after the clock edge. The PC controller adds nextByteOffset_o to the PC before the next edge.

Test Plan:
- Write line 0: bytes 0..3 = 01 02 03 04; bytes 4..11 = 85 86 … 8C; byte 12 = 80, bytes 13..19 = 81..87; remaining bytes 0. Then set pc_i = 0 for one edge.
  -> A = 0x04030201, fmt 0; B = 0x8C8B8A8988878685, fmt 1; enableA = enableB = 1; offset 12; backDisable 0.
- Same line, pc_i = 4 (long at 4, long at 12).
  -> enableA = 1, A = 0x8C8B8A8988878685, enableB = 0, B = 0, offset 8.
- Line 0 byte 24 = 0x10 (short), byte 28 = 0x90 (long); pc_i = 24.
  -> A = bytes 24..27 (0x00000010), enableB = 0, offset 4.
- Same line, pc_i = 28 (long would cross the block end).
  -> enableA = enableB = 0, backDisable = 1, offset 4.
- pc_i = 0x2000 (line index 0 via aliasing).
  -> same outputs as the first scenario.
- Write line 0 with all-zero data and read pc_i = 0 at the same edge.
  -> old data returned (A = 0x04030201); the next edge gives A = 0, fmt 0, B = 0, offset 8.
- Pull reset_i low mid-stream.
  -> all outputs 0 immediately; after release, outputs remain 0 until the first edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus of the fetch unit: PC in, cache line write port in, decoded
// instruction pair and PC advance out.
interface fetch_unit_if;
  logic [15:0]  pc_i;
  logic         writeEnable_i;
  logic [15:0]  writeAddress_i;
  logic [255:0] writeBlock_i;
  logic [63:0]  InstructionA_o;
  logic [63:0]  InstructionB_o;
  logic         InstructionAFormat_o;
  logic         InstructionBFormat_o;
  logic         enableA_o;
  logic         enableB_o;
  logic [3:0]   nextByteOffset_o;
  logic         backDisable_o;

  // The PC controller/refill side drives the master; the fetch unit is the slave.
  modport master (
    output pc_i, writeEnable_i, writeAddress_i, writeBlock_i,
    input  InstructionA_o, InstructionB_o, InstructionAFormat_o,
           InstructionBFormat_o, enableA_o, enableB_o, nextByteOffset_o,
           backDisable_o
  );

  modport slave (
    input  pc_i, writeEnable_i, writeAddress_i, writeBlock_i,
    output InstructionA_o, InstructionB_o, InstructionAFormat_o,
           InstructionBFormat_o, enableA_o, enableB_o, nextByteOffset_o,
           backDisable_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Two-stage fetch: a direct-indexed line cache registers one 32-byte block,
// then combinational logic peels off up to two 4/8-byte instructions from it.
module fetch_unit #(
  parameter int BLOCK_SIZE    = 32,
  parameter int BITS_PER_BYTE = 8,
  parameter int CACHE_LINES   = 256
) (
  input  logic         clock_i,
  input  logic         reset_i,
  fetch_unit_if.slave  bus
);
  localparam int LINE_W = BLOCK_SIZE * BITS_PER_BYTE;
  localparam int IDX_W  = $clog2(CACHE_LINES);

  logic [LINE_W-1:0] r_mem [CACHE_LINES];
  logic [LINE_W-1:0] r_blk;
  logic [4:0]        r_off;
  logic              r_vld;

  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_unused;

  assign w_rd_idx = bus.pc_i[12:5];
  assign w_wr_idx = bus.writeAddress_i[12:5];
  assign w_unused = ^{bus.pc_i[15:13], bus.writeAddress_i[15:13], bus.writeAddress_i[4:0]};

  // Storage is deliberately not reset; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (bus.writeEnable_i) r_mem[w_wr_idx] <= bus.writeBlock_i;
  end

  // Read and write share an edge, so a same-line read sees the old line.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_blk <= '0;
      r_off <= '0;
      r_vld <= 1'b0;
    end else begin
      r_blk <= r_mem[w_rd_idx];
      r_off <= bus.pc_i[4:0];
      r_vld <= 1'b1;
    end
  end

  logic [LINE_W-1:0] w_sh_a;
  logic [LINE_W-1:0] w_sh_b;
  logic              w_fmt_a;
  logic              w_fmt_b;
  logic [3:0]        w_len_a;
  logic [3:0]        w_len_b;
  logic [5:0]        w_end_a;
  logic [5:0]        w_end_b;
  logic [5:0]        w_rem;
  logic              w_cross_a;
  logic              w_issue_a;
  logic              w_issue_b;

  // Shifting the block down puts each instruction's first byte at bit 0;
  // a B start of 32 shifts everything out, which is harmless since B can't fit.
  assign w_sh_a    = r_blk >> {r_off, 3'b000};
  assign w_fmt_a   = w_sh_a[7];
  assign w_len_a   = w_fmt_a ? 4'd8 : 4'd4;
  assign w_end_a   = {1'b0, r_off} + {2'b00, w_len_a};
  assign w_sh_b    = r_blk >> {w_end_a, 3'b000};
  assign w_fmt_b   = w_sh_b[7];
  assign w_len_b   = w_fmt_b ? 4'd8 : 4'd4;
  assign w_end_b   = w_end_a + {2'b00, w_len_b};
  assign w_rem     = 6'd32 - {1'b0, r_off};
  assign w_cross_a = w_end_a > 6'd32;
  assign w_issue_a = r_vld && !w_cross_a;
  assign w_issue_b = w_issue_a && (w_end_b <= 6'd32) && !(w_fmt_a && w_fmt_b);

  always_comb begin
    bus.InstructionA_o       = '0;
    bus.InstructionB_o       = '0;
    bus.InstructionAFormat_o = 1'b0;
    bus.InstructionBFormat_o = 1'b0;
    bus.enableA_o            = 1'b0;
    bus.enableB_o            = 1'b0;
    bus.nextByteOffset_o     = '0;
    bus.backDisable_o        = 1'b0;
    if (r_vld && w_cross_a) begin
      bus.backDisable_o    = 1'b1;
      bus.nextByteOffset_o = w_rem[3:0];
    end else if (w_issue_a) begin
      bus.enableA_o            = 1'b1;
      bus.InstructionAFormat_o = w_fmt_a;
      bus.InstructionA_o       = w_fmt_a ? w_sh_a[63:0] : {32'd0, w_sh_a[31:0]};
      bus.nextByteOffset_o     = w_len_a;
      if (w_issue_b) begin
        bus.enableB_o            = 1'b1;
        bus.InstructionBFormat_o = w_fmt_b;
        bus.InstructionB_o       = w_fmt_b ? w_sh_b[63:0] : {32'd0, w_sh_b[31:0]};
        bus.nextByteOffset_o     = w_len_a + w_len_b;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random line writes and
// fetches, checked against a byte-array model of the cache and decoder.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl [256][32];
  logic [63:0] e_a, e_b;
  logic        e_fa, e_fb, e_ena, e_enb, e_bd;
  logic [3:0]  e_nbo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decoder: walks the model bytes directly.
  task automatic model_expect(input int idx, input int off);
    bit fa, fb;
    int la, lb, ob;
    e_a = '0; e_b = '0; e_fa = 0; e_fb = 0; e_ena = 0; e_enb = 0; e_bd = 0; e_nbo = '0;
    fa = mdl[idx][off][7];
    la = fa ? 8 : 4;
    if (off + la > 32) begin
      e_bd  = 1;
      e_nbo = 4'(32 - off);
    end else begin
      e_ena = 1;
      e_fa  = fa;
      for (int i = 0; i < la; i++) e_a |= 64'(mdl[idx][off+i]) << (8*i);
      e_nbo = 4'(la);
      ob = off + la;
      if (ob < 32) begin
        fb = mdl[idx][ob][7];
        lb = fb ? 8 : 4;
        if (ob + lb <= 32 && !(fa && fb)) begin
          e_enb = 1;
          e_fb  = fb;
          for (int i = 0; i < lb; i++) e_b |= 64'(mdl[idx][ob+i]) << (8*i);
          e_nbo = 4'(la + lb);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_instA"}, bus.InstructionA_o, e_a);
    chk({tag, "_instB"}, bus.InstructionB_o, e_b);
    chk({tag, "_fmtA"},  64'(bus.InstructionAFormat_o), 64'(e_fa));
    chk({tag, "_fmtB"},  64'(bus.InstructionBFormat_o), 64'(e_fb));
    chk({tag, "_enA"},   64'(bus.enableA_o), 64'(e_ena));
    chk({tag, "_enB"},   64'(bus.enableB_o), 64'(e_enb));
    chk({tag, "_nbo"},   64'(bus.nextByteOffset_o), 64'(e_nbo));
    chk({tag, "_bd"},    64'(bus.backDisable_o), 64'(e_bd));
  endtask

  task automatic check_zero(input string tag);
    e_a = '0; e_b = '0; e_fa = 0; e_fb = 0; e_ena = 0; e_enb = 0; e_bd = 0; e_nbo = '0;
    check_all(tag);
  endtask

  // driver: one edge; the model reads before it applies the write
  task automatic step(input string tag, input logic [15:0] pc, input bit we,
                      input logic [15:0] wa, input logic [255:0] wb, input bit do_chk);
    bus.pc_i           = pc;
    bus.writeEnable_i  = we;
    bus.writeAddress_i = wa;
    bus.writeBlock_i   = wb;
    @(posedge clk);
    if (do_chk) model_expect(int'(pc[12:5]), int'(pc[4:0]));
    if (we) for (int k = 0; k < 32; k++) mdl[wa[12:5]][k] = wb[8*k +: 8];
    #1;
    if (do_chk) check_all(tag);
    bus.writeEnable_i = 1'b0;
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] b0;
    logic [15:0]  pc;

    rst_n = 1'b0;
    bus.pc_i = '0; bus.writeEnable_i = 1'b0; bus.writeAddress_i = '0; bus.writeBlock_i = '0;
    #2 check_zero("reset");
    #10 rst_n = 1'b1;
    #1 check_zero("post_release");

    b0 = '0;
    for (int k = 0; k < 4; k++)  b0[8*k +: 8] = 8'(k + 1);
    for (int k = 4; k < 12; k++) b0[8*k +: 8] = 8'(8'h85 + k - 4);
    for (int k = 12; k < 20; k++) b0[8*k +: 8] = 8'(8'h80 + k - 12);
    step("wr0", 16'h0000, 1'b1, 16'h0000, b0, 1'b0);

    step("short_long", 16'h0000, 1'b0, 16'h0, '0, 1'b1);
    chk("s1_const_A", bus.InstructionA_o, 64'h0000_0000_0403_0201);
    chk("s1_const_B", bus.InstructionB_o, 64'h8C8B_8A89_8887_8685);
    chk("s1_const_nbo", 64'(bus.nextByteOffset_o), 64'd12);

    step("long_long", 16'h0004, 1'b0, 16'h0, '0, 1'b1);
    chk("s2_const_enB", 64'(bus.enableB_o), 64'd0);
    chk("s2_const_nbo", 64'(bus.nextByteOffset_o), 64'd8);

    b0[8*24 +: 8] = 8'h10;
    b0[8*28 +: 8] = 8'h90;
    step("wr0b", 16'h0000, 1'b1, 16'h0000, b0, 1'b1);
    step("short_at_24", 16'd24, 1'b0, 16'h0, '0, 1'b1);
    chk("s3_const_A", bus.InstructionA_o, 64'h10);
    step("cross_at_28", 16'd28, 1'b0, 16'h0, '0, 1'b1);
    chk("s4_const_bd", 64'(bus.backDisable_o), 64'd1);
    chk("s4_const_nbo", 64'(bus.nextByteOffset_o), 64'd4);
    step("alias", 16'h2000, 1'b0, 16'h0, '0, 1'b1);
    chk("s5_const_A", bus.InstructionA_o, 64'h0403_0201);

    step("rbw_old", 16'h0000, 1'b1, 16'h0000, '0, 1'b1);
    chk("s6_const_old", bus.InstructionA_o, 64'h0403_0201);
    step("rbw_new", 16'h0000, 1'b0, 16'h0, '0, 1'b1);
    chk("s6_const_nbo", 64'(bus.nextByteOffset_o), 64'd8);

    // random lines 1..15 then random fetches with occasional rewrites
    for (int l = 1; l < 16; l++) step("rwr", 16'h0000, 1'b1, 16'(l << 5), rand_line(), 1'b1);
    for (int n = 0; n < 300; n++) begin
      pc = {3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 7) == 0)
        step("rand_wr", pc, 1'b1, 16'($urandom_range(0, 15) << 5), rand_line(), 1'b1);
      else
        step("rand", pc, 1'b0, 16'h0, '0, 1'b1);
    end

    // asynchronous reset mid-stream
    step("pre_rst", 16'h0020, 1'b0, 16'h0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    #10 check_zero("rst_held");
    #1 rst_n = 1'b1;
    #2 check_zero("rst_released");
    step("after_rst", 16'h0024, 1'b0, 16'h0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
